// File: rtl/cache_pkg.sv
// ============================================================================
// Module : cache_pkg
// Purpose: Shared definitions for the cache controller: default widths, the
//          controller state encoding and the per-way teg_all slice width.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_pkg;

  localparam int unsigned ATEG_WIDTH_DEF   = 7;
  localparam int unsigned AINDEX_WIDTH_DEF = 6;
  localparam int unsigned ACH_WIDTH_DEF    = 3;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WBACK  = 3'd2,
    ST_REFILL = 3'd3,
    ST_ALLOC  = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // Each way in teg_all carries {tag, val, mod}.
  function automatic int unsigned teg_slice_w(input int unsigned tag_w);
    return tag_w + 2;
  endfunction

  localparam int unsigned TEG_SLICE_W_DEF = ATEG_WIDTH_DEF + 2;

endpackage

`default_nettype wire

// File: rtl/repl_fifo_ptr.sv
// ============================================================================
// Module : repl_fifo_ptr
// Purpose: Per-set FIFO replacement pointer array. One pointer per set,
//          combinational read, increment (wrapping) on enable, synchronous
//          active-low clear of every pointer.
// Ports  : clk, reset (sync, active-low), idx_i (set index), inc_i
//          (advance pointer of idx_i), ptr_o (pointer of idx_i)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module repl_fifo_ptr #(
  parameter int unsigned IDX_WIDTH = 6,
  parameter int unsigned PTR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_WIDTH-1:0] idx_i,
  input  logic                 inc_i,
  output logic [PTR_WIDTH-1:0] ptr_o
);

  localparam int unsigned SETS = 2**IDX_WIDTH;

  logic [PTR_WIDTH-1:0] ptr_q [SETS];

  // Pointer width equals log2(ways), so natural overflow is the wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(SETS); i++) begin
        ptr_q[i] <= '0;
      end
    end else if (inc_i) begin
      ptr_q[idx_i] <= ptr_q[idx_i] + PTR_WIDTH'(1);
    end
  end

  assign ptr_o = ptr_q[idx_i];

endmodule

`default_nettype wire

// File: rtl/cache_ctrl.sv
// ============================================================================
// Module : cache_ctrl
// Purpose: Set-associative cache controller. Accepts one CPU request at a
//          time, looks it up in the external tag channels, writes back a
//          dirty FIFO victim, refills from backing memory, allocates the tag
//          and signals completion.
// Ports  : clk, reset (sync, active-low)
//          CPU   : cpu_req, cpu_we, cpu_addr, cpu_ready, cpu_done
//          Tags  : hit_vec, teg_all, tag_addr, tag_wr, tag_md, fifo, hit_all
//          Memory: mem_req, mem_we, mem_addr, mem_ack
//          Stats : hit_cnt, miss_cnt (only with CACHE_CTRL_STATS_EN)
// Config : define CACHE_CTRL_STATS_EN to add saturating 16-bit hit/miss
//          counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ATEG_WIDTH   = ATEG_WIDTH_DEF,
  parameter int unsigned AINDEX_WIDTH = AINDEX_WIDTH_DEF,
  parameter int unsigned ACH_WIDTH    = ACH_WIDTH_DEF
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          cpu_req,
  input  logic                                          cpu_we,
  input  logic [ATEG_WIDTH+AINDEX_WIDTH-1:0]            cpu_addr,
  output logic                                          cpu_ready,
  output logic                                          cpu_done,
  input  logic [(2**ACH_WIDTH)-1:0]                     hit_vec,
  input  logic [(2**ACH_WIDTH)*(ATEG_WIDTH+2)-1:0]      teg_all,
  output logic [ATEG_WIDTH+AINDEX_WIDTH-1:0]            tag_addr,
  output logic                                          tag_wr,
  output logic                                          tag_md,
  output logic [ACH_WIDTH-1:0]                          fifo,
  output logic                                          hit_all,
  output logic                                          mem_req,
  output logic                                          mem_we,
  output logic [ATEG_WIDTH+AINDEX_WIDTH-1:0]            mem_addr,
  input  logic                                          mem_ack
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]                                   hit_cnt,
  output logic [15:0]                                   miss_cnt
`endif
);

  localparam int unsigned SLICE_W = teg_slice_w(ATEG_WIDTH);
  localparam int unsigned AW      = ATEG_WIDTH + AINDEX_WIDTH;

  state_e                  state_q, state_d;
  logic [AW-1:0]           addr_q;
  logic                    we_q;
  logic [ATEG_WIDTH-1:0]   vtag_q;

  logic                    w_hit;
  logic [SLICE_W-1:0]      w_victim;
  logic [AINDEX_WIDTH-1:0] w_idx;
  logic                    w_ptr_inc;

  assign w_idx    = addr_q[AINDEX_WIDTH-1:0];
  assign w_hit    = |hit_vec;
  assign w_victim = teg_all[int'(fifo)*int'(SLICE_W) +: SLICE_W];

  // Pointer only advances on a completed allocation; a reset during ALLOC
  // wins inside the pointer array, so an aborted access never bumps it.
  assign w_ptr_inc = (state_q == ST_ALLOC);

  repl_fifo_ptr #(
    .IDX_WIDTH (AINDEX_WIDTH),
    .PTR_WIDTH (ACH_WIDTH)
  ) u_repl (
    .clk   (clk),
    .reset (reset),
    .idx_i (w_idx),
    .inc_i (w_ptr_inc),
    .ptr_o (fifo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cpu_req) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (w_hit)                        state_d = ST_RESP;
        else if (w_victim[1] && w_victim[0]) state_d = ST_WBACK;
        else                              state_d = ST_REFILL;
      end
      ST_WBACK:  if (mem_ack) state_d = ST_REFILL;
      ST_REFILL: if (mem_ack) state_d = ST_ALLOC;
      ST_ALLOC:  state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request and victim-tag capture. The victim tag is frozen in LOOKUP so the
  // write-back address stays stable even if teg_all changes while waiting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      vtag_q <= '0;
    end else begin
      if (state_q == ST_IDLE && cpu_req) begin
        addr_q <= cpu_addr;
        we_q   <= cpu_we;
      end
      if (state_q == ST_LOOKUP) begin
        vtag_q <= w_victim[SLICE_W-1:2];
      end
    end
  end

  // Output logic
  always_comb begin
    cpu_ready = (state_q == ST_IDLE);
    cpu_done  = (state_q == ST_RESP);
    tag_addr  = addr_q;
    tag_wr    = (state_q == ST_ALLOC);
    hit_all   = (state_q == ST_LOOKUP) && w_hit;
    tag_md    = ((state_q == ST_LOOKUP) && w_hit && we_q) ||
                ((state_q == ST_ALLOC) && we_q);
    mem_req   = (state_q == ST_WBACK) || (state_q == ST_REFILL);
    mem_we    = (state_q == ST_WBACK);
    mem_addr  = (state_q == ST_WBACK) ? {vtag_q, w_idx} : addr_q;
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == ST_LOOKUP) begin
      if (w_hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl.sv
// ============================================================================
// Module : tb_cache_ctrl
// Purpose: Directed self-checking bench for cache_ctrl (default parameters:
//          7-bit tag, 6-bit index, 8 ways).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cache_ctrl;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic        cpu_ready;
  logic        cpu_done;
  logic [7:0]  hit_vec;
  logic [71:0] teg_all;
  logic [12:0] tag_addr;
  logic        tag_wr;
  logic        tag_md;
  logic [2:0]  fifo;
  logic        hit_all;
  logic        mem_req;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic        mem_ack;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cache_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .hit_vec   (hit_vec),
    .teg_all   (teg_all),
    .tag_addr  (tag_addr),
    .tag_wr    (tag_wr),
    .tag_md    (tag_md),
    .fifo      (fifo),
    .hit_all   (hit_all),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Control vector order used below: {cpu_ready, cpu_done, mem_req, tag_wr, tag_md, hit_all}
  task automatic test_reset;
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    hit_vec = '0; teg_all = '0; mem_ack = 1'b0;
    tick; tick;
    checks++;
    if ({cpu_ready, cpu_done, mem_req, tag_wr, tag_md, hit_all} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 100000",
               {cpu_ready, cpu_done, mem_req, tag_wr, tag_md, hit_all});
    end
    checks++;
    if ({tag_addr, fifo} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_addr_fifo: got tag_addr=%h fifo=%0d want 0/0", tag_addr, fifo);
    end
    reset = 1'b1;
    tick;
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", cpu_ready);
    end
  endtask

  task automatic test_cold_read;
    cpu_req = 1'b1; cpu_addr = 13'h0041; cpu_we = 1'b0;
    tick;                                   // acceptance -> LOOKUP
    cpu_req = 1'b0;
    checks++;
    if ({cpu_ready, mem_req, hit_all, tag_addr, fifo} !== {3'b000, 13'h0041, 3'd0}) begin
      errors++;
      $display("FAIL cold_lookup: got rdy=%b mreq=%b hit=%b taddr=%h fifo=%0d want 0 0 0 0041 0",
               cpu_ready, mem_req, hit_all, tag_addr, fifo);
    end
    tick;                                   // REFILL, no write-back for invalid victim
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 13'h0041}) begin
      errors++;
      $display("FAIL cold_refill: got req=%b we=%b addr=%h want 1 0 0041", mem_req, mem_we, mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({mem_req, mem_we, mem_addr, cpu_done} !== {2'b10, 13'h0041, 1'b0}) begin
        errors++;
        $display("FAIL cold_refill_hold: cyc %0d got req=%b we=%b addr=%h done=%b want 1 0 0041 0",
                 i, mem_req, mem_we, mem_addr, cpu_done);
      end
    end
    mem_ack = 1'b1;
    tick;                                   // ALLOC
    mem_ack = 1'b0;
    checks++;
    if ({tag_wr, tag_md, hit_all, mem_req, fifo} !== {4'b1000, 3'd0}) begin
      errors++;
      $display("FAIL cold_alloc: got wr=%b md=%b hit=%b mreq=%b fifo=%0d want 1 0 0 0 0",
               tag_wr, tag_md, hit_all, mem_req, fifo);
    end
    tick;                                   // RESP
    checks++;
    if ({cpu_done, tag_wr, fifo} !== {2'b10, 3'd1}) begin
      errors++;
      $display("FAIL cold_resp: got done=%b wr=%b fifo=%0d want 1 0 1", cpu_done, tag_wr, fifo);
    end
    tick;                                   // IDLE
    checks++;
    if ({cpu_ready, cpu_done} !== 2'b10) begin
      errors++;
      $display("FAIL cold_idle: got rdy=%b done=%b want 1 0", cpu_ready, cpu_done);
    end
  endtask

  task automatic test_write_hit;
    // Write hit on way 2
    cpu_req = 1'b1; cpu_addr = 13'h0085; cpu_we = 1'b1; hit_vec = 8'h04;
    tick;
    cpu_req = 1'b0;
    checks++;
    if ({cpu_ready, cpu_done, mem_req, tag_wr, tag_md, hit_all} !== 6'b000011) begin
      errors++;
      $display("FAIL whit_lookup: got %b want 000011",
               {cpu_ready, cpu_done, mem_req, tag_wr, tag_md, hit_all});
    end
    tick;
    checks++;
    if ({cpu_ready, cpu_done, mem_req, tag_wr, tag_md, hit_all, fifo} !== {6'b010000, 3'd0}) begin
      errors++;
      $display("FAIL whit_resp: got %b fifo=%0d want 010000 fifo=0",
               {cpu_ready, cpu_done, mem_req, tag_wr, tag_md, hit_all}, fifo);
    end
    tick;
    // Read with two ways hitting at once behaves as one hit
    cpu_req = 1'b1; cpu_addr = 13'h0105; cpu_we = 1'b0; hit_vec = 8'hA0;
    tick;
    cpu_req = 1'b0;
    checks++;
    if ({cpu_ready, cpu_done, mem_req, tag_wr, tag_md, hit_all} !== 6'b000001) begin
      errors++;
      $display("FAIL multihit_lookup: got %b want 000001",
               {cpu_ready, cpu_done, mem_req, tag_wr, tag_md, hit_all});
    end
    tick;
    checks++;
    if ({cpu_done, mem_req, fifo} !== {2'b10, 3'd0}) begin
      errors++;
      $display("FAIL multihit_resp: got done=%b mreq=%b fifo=%0d want 1 0 0", cpu_done, mem_req, fifo);
    end
    tick;
    hit_vec = '0;
  endtask

  task automatic test_writeback;
    // Way 0 of set 3 holds {tag 0x15, val 1, mod 1}; request tag 0x2A in set 3
    teg_all = 72'h57;
    cpu_req = 1'b1; cpu_addr = 13'h0A83; cpu_we = 1'b0;
    tick;
    cpu_req = 1'b0;
    tick;                                   // WBACK
    teg_all = '0;                           // victim tag must already be latched
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {2'b11, 13'h0543}) begin
      errors++;
      $display("FAIL wb_addr: got req=%b we=%b addr=%h want 1 1 0543", mem_req, mem_we, mem_addr);
    end
    tick;
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {2'b11, 13'h0543}) begin
      errors++;
      $display("FAIL wb_hold: got req=%b we=%b addr=%h want 1 1 0543", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1;
    tick;                                   // REFILL
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 13'h0A83}) begin
      errors++;
      $display("FAIL wb_refill: got req=%b we=%b addr=%h want 1 0 0a83", mem_req, mem_we, mem_addr);
    end
    tick;                                   // ALLOC
    mem_ack = 1'b0;
    checks++;
    if ({tag_wr, fifo} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL wb_alloc: got wr=%b fifo=%0d want 1 0", tag_wr, fifo);
    end
    tick;
    checks++;
    if ({cpu_done, fifo} !== {1'b1, 3'd1}) begin
      errors++;
      $display("FAIL wb_resp: got done=%b fifo=%0d want 1 1", cpu_done, fifo);
    end
    tick;
  endtask

  task automatic test_wrap;
    // Every way valid but clean: misses refill without write-back
    teg_all = {8{9'h002}};
    for (int k = 0; k < 9; k++) begin
      cpu_req = 1'b1; cpu_addr = 13'((k << 6) | 7); cpu_we = 1'b0;
      tick;
      cpu_req = 1'b0;
      tick;                                 // REFILL
      checks++;
      if ({mem_req, mem_we} !== 2'b10) begin
        errors++;
        $display("FAIL wrap_refill: miss %0d got req=%b we=%b want 1 0", k, mem_req, mem_we);
      end
      mem_ack = 1'b1;
      tick;                                 // ALLOC
      mem_ack = 1'b0;
      checks++;
      if ({tag_wr, fifo} !== {1'b1, 3'(k % 8)}) begin
        errors++;
        $display("FAIL wrap_fifo: miss %0d got wr=%b fifo=%0d want 1 %0d", k, tag_wr, fifo, k % 8);
      end
      tick;
      tick;
    end
    teg_all = '0;
  endtask

  task automatic test_back_to_back;
    int early_ready;
    bit done_seen;
    early_ready = 0;
    done_seen   = 1'b0;
    teg_all = {8{9'h002}};
    cpu_req = 1'b1; cpu_addr = 13'h00C5; cpu_we = 1'b0;
    tick;                                   // LOOKUP
    tick;                                   // REFILL
    tick;                                   // still REFILL, no ack yet
    checks++;
    if ({cpu_ready, mem_req, mem_addr} !== {2'b01, 13'h00C5}) begin
      errors++;
      $display("FAIL b2b_hold: got rdy=%b req=%b addr=%h want 0 1 00c5", cpu_ready, mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick;
      mem_ack = 1'b0;
      if (cpu_ready) early_ready++;
      if (cpu_done) begin
        done_seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!done_seen || early_ready != 0) begin
      errors++;
      $display("FAIL b2b_done: got done_seen=%0d early_ready=%0d want 1 0", done_seen, early_ready);
    end
    tick;                                   // IDLE, request still pending
    hit_vec = 8'h01;
    checks++;
    if ({cpu_ready, cpu_done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_idle: got rdy=%b done=%b want 1 0", cpu_ready, cpu_done);
    end
    tick;                                   // second acceptance
    cpu_req = 1'b0;
    checks++;
    if ({cpu_ready, hit_all, tag_addr, fifo} !== {2'b01, 13'h00C5, 3'd1}) begin
      errors++;
      $display("FAIL b2b_second: got rdy=%b hit=%b taddr=%h fifo=%0d want 0 1 00c5 1",
               cpu_ready, hit_all, tag_addr, fifo);
    end
    tick;
    tick;
    hit_vec = '0;
    teg_all = '0;
  endtask

  task automatic test_reset_abort;
    int bad;
    bad = 0;
    // First miss to set 2 moves its pointer to 1
    cpu_req = 1'b1; cpu_addr = 13'h0042; cpu_we = 1'b1;
    tick;
    cpu_req = 1'b0;
    tick;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    tick;
    tick;
    cpu_req = 1'b1; cpu_addr = 13'h0042; cpu_we = 1'b1;
    tick;
    cpu_req = 1'b0;
    checks++;
    if (fifo !== 3'd1) begin
      errors++;
      $display("FAIL abort_pre_fifo: got %0d want 1", fifo);
    end
    tick;                                   // REFILL
    reset = 1'b0;
    tick;
    checks++;
    if ({cpu_ready, cpu_done, mem_req, tag_wr, tag_md, hit_all, tag_addr} !== {6'b100000, 13'h0000}) begin
      errors++;
      $display("FAIL abort_state: got %b taddr=%h want 100000 0000",
               {cpu_ready, cpu_done, mem_req, tag_wr, tag_md, hit_all}, tag_addr);
    end
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick;
      if (cpu_done !== 1'b0 || cpu_ready !== 1'b1 || tag_wr !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d bad cycles want 0", bad);
    end
    cpu_req = 1'b1; cpu_addr = 13'h0042; cpu_we = 1'b0; hit_vec = 8'h10;
    tick;
    cpu_req = 1'b0;
    checks++;
    if (fifo !== 3'd0) begin
      errors++;
      $display("FAIL abort_ptr_cleared: got %0d want 0", fifo);
    end
    tick;
    tick;
    hit_vec = '0;
  endtask

  initial begin
    test_reset;
    test_cold_read;
    test_write_hit;
    test_writeback;
    test_wrap;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
